// File: rtl/rectify.sv
// rectify: saturating rectifier activation stage placed after associate.
//  Forward path clamps a signed pre-activation to an unsigned ACTW-bit value.
//  Backward path gates the incoming error by the derivative region recorded
//  for the oldest pending forward sample (strict FIFO order).
//  Optional feature macro: RECTIFY_LEAKY_EN (BELOW region passes err >>> 3).
module rectify #(
  parameter int RESW  = 16,
  parameter int ACTW  = 8,
  parameter int ERRW  = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       arg_valid,
  input  logic [RESW-1:0]            arg_data,
  output logic                       arg_ready,
  output logic                       res_valid,
  output logic [ACTW-1:0]            res_data,
  input  logic                       res_ready,
  input  logic                       err_valid,
  input  logic [ERRW-1:0]            err_data,
  output logic                       err_ready,
  output logic                       fbk_valid,
  output logic [ERRW-1:0]            fbk_data,
  input  logic                       fbk_ready,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Region codes describe which piece of the clamp each forward sample hit.
  localparam logic [1:0] REG_BELOW  = 2'd0;
  localparam logic [1:0] REG_LINEAR = 2'd1;
  localparam logic [1:0] REG_ABOVE  = 2'd2;

  // Saturation ceiling widened to the input width for a plain compare.
  localparam logic [RESW-1:0] ACT_MAX = {{(RESW-ACTW){1'b0}}, {ACTW{1'b1}}};

  // Clamp a signed value into [0, 2**ACTW-1].
  function automatic logic [ACTW-1:0] sat_f(input logic [RESW-1:0] x);
    logic [ACTW-1:0] r;
    if (x[RESW-1]) begin
      r = {ACTW{1'b0}};
    end else if (x > ACT_MAX) begin
      r = {ACTW{1'b1}};
    end else begin
      r = x[ACTW-1:0];
    end
    return r;
  endfunction

  // Classify a signed value into its clamp region (endpoints are LINEAR).
  function automatic logic [1:0] region_f(input logic [RESW-1:0] x);
    logic [1:0] r;
    if (x[RESW-1]) begin
      r = REG_BELOW;
    end else if (x > ACT_MAX) begin
      r = REG_ABOVE;
    end else begin
      r = REG_LINEAR;
    end
    return r;
  endfunction

  logic            res_valid_r;
  logic [ACTW-1:0] res_data_r;
  logic            fbk_valid_r;
  logic [ERRW-1:0] fbk_data_r;
  logic [1:0]      region_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;

  logic            full_s;
  logic            empty_s;
  logic            arg_ready_s;
  logic            err_ready_s;
  logic            arg_acc_s;
  logic            err_acc_s;
  logic            push_s;
  logic            pop_s;
  logic [ERRW-1:0] gated_s;

  // Handshake and FIFO control, all from pre-edge state (no bypass).
  always_comb begin
    full_s      = (count_r == CW'(DEPTH));
    empty_s     = (count_r == {CW{1'b0}});
    arg_ready_s = (!res_valid_r || res_ready) && !(en && full_s);
    err_ready_s = (!fbk_valid_r || fbk_ready) && !empty_s;
    arg_acc_s   = arg_valid && arg_ready_s;
    err_acc_s   = err_valid && err_ready_s;
    push_s      = arg_acc_s && en;
    pop_s       = err_acc_s;
  end

  // Gate the error by the derivative region at the FIFO head.
  always_comb begin
    gated_s = {ERRW{1'b0}};
    case (region_r[rd_ptr_r])
      REG_LINEAR: gated_s = err_data;
`ifdef RECTIFY_LEAKY_EN
      REG_BELOW:  gated_s = $signed(err_data) >>> 3;
`else
      REG_BELOW:  gated_s = {ERRW{1'b0}};
`endif
      REG_ABOVE:  gated_s = {ERRW{1'b0}};
      default:    gated_s = {ERRW{1'b0}};
    endcase
  end

  // Forward output register: load on accept, drop when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_data_r  <= {ACTW{1'b0}};
    end else if (arg_acc_s) begin
      res_valid_r <= 1'b1;
      res_data_r  <= sat_f(arg_data);
    end else if (res_ready) begin
      res_valid_r <= 1'b0;
      res_data_r  <= res_data_r;
    end else begin
      res_valid_r <= res_valid_r;
      res_data_r  <= res_data_r;
    end
  end

  // Backward output register: load gated error on accept, drop when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fbk_valid_r <= 1'b0;
      fbk_data_r  <= {ERRW{1'b0}};
    end else if (err_acc_s) begin
      fbk_valid_r <= 1'b1;
      fbk_data_r  <= gated_s;
    end else if (fbk_ready) begin
      fbk_valid_r <= 1'b0;
      fbk_data_r  <= fbk_data_r;
    end else begin
      fbk_valid_r <= fbk_valid_r;
      fbk_data_r  <= fbk_data_r;
    end
  end

  // Region FIFO storage: write the new region at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        region_r[i] <= REG_BELOW;
      end
    end else if (push_s) begin
      region_r[wr_ptr_r] <= region_f(arg_data);
    end else begin
      region_r[wr_ptr_r] <= region_r[wr_ptr_r];
    end
  end

  // Region FIFO pointers and occupancy; pointers wrap naturally mod DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign arg_ready = arg_ready_s;
  assign err_ready = err_ready_s;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign fbk_valid = fbk_valid_r;
  assign fbk_data  = fbk_data_r;
  assign pending   = count_r;

endmodule

// File: tb/tb_rectify.sv
// Directed bench for rectify (default parameters, DEPTH=4).
module tb_rectify;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        arg_valid;
  logic [15:0] arg_data;
  logic        arg_ready;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        res_ready;
  logic        err_valid;
  logic [15:0] err_data;
  logic        err_ready;
  logic        fbk_valid;
  logic [15:0] fbk_data;
  logic        fbk_ready;
  logic [2:0]  pending;

  int checks = 0;
  int errors = 0;

  rectify dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .arg_valid(arg_valid), .arg_data(arg_data), .arg_ready(arg_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .err_valid(err_valid), .err_data(err_data), .err_ready(err_ready),
    .fbk_valid(fbk_valid), .fbk_data(fbk_data), .fbk_ready(fbk_ready),
    .pending(pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One forward transfer, then check the activation and FIFO occupancy.
  task automatic fwd_chk(input logic [15:0] d, input logic [7:0] exp_res, input logic [2:0] exp_pend);
    @(negedge clk);
    arg_valid = 1'b1;
    arg_data  = d;
    @(negedge clk);
    arg_valid = 1'b0;
    chk("fwd_valid", res_valid, 1'b1);
    chk("fwd_data", res_data, exp_res);
    chk("fwd_pending", pending, exp_pend);
  endtask

  // One backward transfer, then check the gated error and FIFO occupancy.
  task automatic bwd_chk(input logic [15:0] e, input logic [15:0] exp_fbk, input logic [2:0] exp_pend);
    @(negedge clk);
    err_valid = 1'b1;
    err_data  = e;
    @(negedge clk);
    err_valid = 1'b0;
    chk("bwd_valid", fbk_valid, 1'b1);
    chk("bwd_data", fbk_data, exp_fbk);
    chk("bwd_pending", pending, exp_pend);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    arg_valid = 1'b0; arg_data = 16'h0000; res_ready = 1'b1;
    err_valid = 1'b0; err_data = 16'h0000; fbk_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 8'h00);
    chk("rst_fbk_valid", fbk_valid, 1'b0);
    chk("rst_pending", pending, 3'd0);
    chk("rst_arg_ready", arg_ready, 1'b1);
    chk("rst_err_ready", err_ready, 1'b0);
    rst_n = 1'b1;

    // Forward clamp with training disabled.
    fwd_chk(16'hff00, 8'h00, 3'd0);
    fwd_chk(16'h0000, 8'h00, 3'd0);
    fwd_chk(16'h0080, 8'h80, 3'd0);
    fwd_chk(16'h00ff, 8'hff, 3'd0);
    fwd_chk(16'h0100, 8'hff, 3'd0);

    // Gating by region.
    en = 1'b1;
    fwd_chk(16'h0080, 8'h80, 3'd1);
    bwd_chk(16'h0010, 16'h0010, 3'd0);
    fwd_chk(16'h0200, 8'hff, 3'd1);
    bwd_chk(16'h0010, 16'h0000, 3'd0);
    fwd_chk(16'hfffb, 8'h00, 3'd1);
`ifdef RECTIFY_LEAKY_EN
    bwd_chk(16'h0010, 16'h0002, 3'd0);
`else
    bwd_chk(16'h0010, 16'h0000, 3'd0);
`endif
`ifdef RECTIFY_LEAKY_EN
    fwd_chk(16'h8000, 8'h00, 3'd1);
    bwd_chk(16'hff80, 16'hfff0, 3'd0);
`endif

    // Full FIFO then drain in order.
    fwd_chk(16'h0040, 8'h40, 3'd1);
    fwd_chk(16'h0300, 8'hff, 3'd2);
    fwd_chk(16'hff00, 8'h00, 3'd3);
    fwd_chk(16'h00ff, 8'hff, 3'd4);
    chk("full_arg_ready", arg_ready, 1'b0);
    @(negedge clk);
    arg_valid = 1'b1;
    arg_data  = 16'h0011;
    @(negedge clk);
    arg_valid = 1'b0;
    chk("full_no_push", pending, 3'd4);
    bwd_chk(16'h0040, 16'h0040, 3'd3);
    chk("pop_arg_ready", arg_ready, 1'b1);
`ifdef RECTIFY_LEAKY_EN
    bwd_chk(16'h0040, 16'h0000, 3'd2);
    bwd_chk(16'h0040, 16'h0008, 3'd1);
`else
    bwd_chk(16'h0040, 16'h0000, 3'd2);
    bwd_chk(16'h0040, 16'h0000, 3'd1);
`endif
    bwd_chk(16'h0040, 16'h0040, 3'd0);

    // Forward backpressure (no FIFO traffic).
    en = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    arg_valid = 1'b1;
    arg_data  = 16'h0050;
    @(negedge clk);
    arg_data  = 16'h0060;
    for (int i = 0; i < 3; i++) begin
      chk("bp_res_valid", res_valid, 1'b1);
      chk("bp_res_data", res_data, 8'h50);
      chk("bp_arg_ready", arg_ready, 1'b0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    arg_valid = 1'b0;
    chk("bp_res_next", res_data, 8'h60);

    // Backward backpressure.
    en = 1'b1;
    fwd_chk(16'h0020, 8'h20, 3'd1);
    fwd_chk(16'h0030, 8'h30, 3'd2);
    @(negedge clk);
    fbk_ready = 1'b0;
    err_valid = 1'b1;
    err_data  = 16'h0011;
    @(negedge clk);
    err_data  = 16'h0022;
    for (int i = 0; i < 3; i++) begin
      chk("bp_fbk_valid", fbk_valid, 1'b1);
      chk("bp_fbk_data", fbk_data, 16'h0011);
      chk("bp_err_ready", err_ready, 1'b0);
      chk("bp_pending", pending, 3'd1);
      @(negedge clk);
    end
    fbk_ready = 1'b1;
    @(negedge clk);
    err_valid = 1'b0;
    chk("bp_fbk_next", fbk_data, 16'h0022);
    chk("bp_pending_end", pending, 3'd0);

    // Simultaneous push and pop at pending=2.
    fwd_chk(16'h0001, 8'h01, 3'd1);
    fwd_chk(16'h0400, 8'hff, 3'd2);
    @(negedge clk);
    arg_valid = 1'b1; arg_data = 16'h0010;
    err_valid = 1'b1; err_data = 16'h0005;
    @(negedge clk);
    arg_valid = 1'b0; err_valid = 1'b0;
    chk("pp_pending", pending, 3'd2);
    chk("pp_res", res_data, 8'h10);
    chk("pp_fbk", fbk_data, 16'h0005);
    bwd_chk(16'h0007, 16'h0000, 3'd1);
    bwd_chk(16'h0009, 16'h0009, 3'd0);

    // Empty FIFO: no pop in the cycle of the push.
    @(negedge clk);
    arg_valid = 1'b1; arg_data = 16'h0033;
    err_valid = 1'b1; err_data = 16'h0044;
    #1;
    chk("empty_err_ready", err_ready, 1'b0);
    @(negedge clk);
    arg_valid = 1'b0;
    chk("empty_fbk_valid", fbk_valid, 1'b0);
    chk("empty_pending", pending, 3'd1);
    chk("empty_err_ready2", err_ready, 1'b1);
    @(negedge clk);
    err_valid = 1'b0;
    chk("empty_fbk_late", fbk_data, 16'h0044);
    chk("empty_pending_end", pending, 3'd0);

    // Mid-stream reset with entries pending and handshakes in flight.
    fwd_chk(16'h0070, 8'h70, 3'd1);
    @(negedge clk);
    fbk_ready = 1'b0;
    arg_valid = 1'b1; arg_data = 16'h0071;
    err_valid = 1'b1; err_data = 16'h0072;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_res_valid", res_valid, 1'b0);
    chk("mid_res_data", res_data, 8'h00);
    chk("mid_fbk_valid", fbk_valid, 1'b0);
    chk("mid_fbk_data", fbk_data, 16'h0000);
    chk("mid_pending", pending, 3'd0);
    chk("mid_arg_ready", arg_ready, 1'b1);
    chk("mid_err_ready", err_ready, 1'b0);
    arg_valid = 1'b0; err_valid = 1'b0; fbk_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_pending", pending, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
